// File: rtl/predecode_queue_pkg.sv
// Shared CPU definitions: instruction field enums, the predecoded entry record
// and small opcode-class helpers used by the fetch-side predecoder.
package predecode_queue_pkg;

  localparam int INST_W = 32;

  typedef logic [4:0] regid_t;

  localparam regid_t LINK_REG = regid_t'(31);

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_BLEZ    = 6'h06,
    OP_BGTZ    = 6'h07,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0A,
    OP_SLTIU   = 6'h0B,
    OP_ANDI    = 6'h0C,
    OP_ORI     = 6'h0D,
    OP_XORI    = 6'h0E,
    OP_LUI     = 6'h0F,
    OP_LB      = 6'h20,
    OP_LH      = 6'h21,
    OP_LW      = 6'h23,
    OP_LBU     = 6'h24,
    OP_LHU     = 6'h25,
    OP_SB      = 6'h28,
    OP_SH      = 6'h29,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_SRA  = 6'h03,
    FN_JR   = 6'h08,
    FN_JALR = 6'h09,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [4:0] {
    BT_BLTZ   = 5'h00,
    BT_BGEZ   = 5'h01,
    BT_BLTZAL = 5'h10,
    BT_BGEZAL = 5'h11
  } btype_t;

  typedef struct packed {
    logic [31:0] pc;
    opcode_t     opcode;
    regid_t      ra;
    regid_t      rb;
    regid_t      rc;
    logic [4:0]  shamt;
    funct_t      funct;
    btype_t      btype;
    logic [31:0] val_c;
    logic [31:0] target;
    logic        is_branch;
    logic        is_jump;
    logic        is_indirect;
    logic        link;
    logic        rsv;
  } predec_t;

  // Opcodes whose immediate is sign-extended into val_c with rA/rB populated.
  function automatic logic is_sext_imm_op(input opcode_t op);
    return op inside {OP_ADDIU, OP_SLTI, OP_SLTIU,
                      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                      OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_zext_imm_op(input opcode_t op);
    return op inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/predecode_queue_if.sv
// Fetch-to-decode bundle: enqueue handshake from fetch, flush, and the
// multi-slot dequeue window presented to decode.
interface predecode_queue_if
  import predecode_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DEQ_W = 2
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [INST_W-1:0]     in_pc;
  logic [INST_W-1:0]     in_inst;
  logic                  flush;
  logic [DEQ_W-1:0]      out_valid;
  predec_t [DEQ_W-1:0]   out_entry;
  logic [DEQ_W-1:0]      deq_ready;
  logic [CNT_W-1:0]      count;

  modport master (
    output in_valid, in_pc, in_inst, flush, deq_ready,
    input  in_ready, out_valid, out_entry, count
  );

  modport slave (
    input  in_valid, in_pc, in_inst, flush, deq_ready,
    output in_ready, out_valid, out_entry, count
  );

endinterface

// File: rtl/predecode_queue_unit.sv
// Combinational MIPS-I subset predecoder: raw word plus PC to a predec_t record.
// Unlisted opcodes produce a reserved entry carrying only pc and opcode.
module predecode_unit
  import predecode_queue_pkg::*;
(
  input  logic [INST_W-1:0] pc,
  input  logic [INST_W-1:0] inst,
  output predec_t           entry
);

  opcode_t     opcode;
  funct_t      funct;
  logic [31:0] pc_plus4;
  logic [31:0] sext_imm;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign opcode    = opcode_t'(inst[31:26]);
  assign funct     = funct_t'(inst[5:0]);
  assign pc_plus4  = pc + 32'd4;
  assign sext_imm  = sext16(inst[15:0]);
  assign br_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], inst[25:0], 2'b00};

  always_comb begin
    // NOTE: every output field gets a default first so no path infers a latch.
    entry        = '0;
    entry.pc     = pc;
    entry.opcode = opcode;
    case (opcode)
      OP_SPECIAL: begin
        entry.ra    = inst[25:21];
        entry.rb    = inst[20:16];
        entry.rc    = inst[15:11];
        entry.shamt = inst[10:6];
        entry.funct = funct;
        if (funct == FN_JR || funct == FN_JALR) begin
          entry.is_jump     = 1'b1;
          entry.is_indirect = 1'b1;
        end
        if (funct == FN_JALR) entry.link = 1'b1;
      end
      OP_REGIMM: begin
        entry.ra        = inst[25:21];
        entry.btype     = btype_t'(inst[20:16]);
        entry.is_branch = 1'b1;
        entry.target    = br_target;
        if (entry.btype inside {BT_BLTZAL, BT_BGEZAL}) begin
          entry.link = 1'b1;
          entry.rc   = LINK_REG;
        end
      end
      OP_BEQ, OP_BNE: begin
        entry.ra        = inst[25:21];
        entry.rb        = inst[20:16];
        entry.is_branch = 1'b1;
        entry.target    = br_target;
      end
      OP_BLEZ, OP_BGTZ: begin
        entry.ra        = inst[25:21];
        entry.is_branch = 1'b1;
        entry.target    = br_target;
      end
      OP_J: begin
        entry.is_jump = 1'b1;
        entry.target  = j_target;
      end
      OP_JAL: begin
        entry.is_jump = 1'b1;
        entry.target  = j_target;
        entry.link    = 1'b1;
        entry.rc      = LINK_REG;
      end
      OP_LUI: begin
        entry.rb    = inst[20:16];
        entry.val_c = {inst[15:0], 16'h0000};
      end
      default: begin
        if (is_sext_imm_op(opcode)) begin
          entry.ra    = inst[25:21];
          entry.rb    = inst[20:16];
          entry.val_c = sext_imm;
        end else if (is_zext_imm_op(opcode)) begin
          entry.ra    = inst[25:21];
          entry.rb    = inst[20:16];
          entry.val_c = {16'h0000, inst[15:0]};
        end else begin
          entry.rsv = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/predecode_queue.sv
// Circular queue of predecoded fetch words; decouples fetch from decode stalls
// and presents up to DEQ_W oldest entries per cycle, oldest in slot 0.
module predecode_queue
  import predecode_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DEQ_W = 2
)
(
  input logic               clk,
  input logic               reset,
  predecode_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  ptr_t    head_q;
  ptr_t    tail_q;
  cnt_t    count_q;
  predec_t mem [DEPTH];

  predec_t enq_entry;
  logic    enq;
  logic    deq_run;
  cnt_t    deq_req;
  cnt_t    deq_n;

  predecode_unit u_predecode (
    .pc    (bus.in_pc),
    .inst  (bus.in_inst),
    .entry (enq_entry)
  );

  // Readiness comes from registered occupancy only: no pass-through when full.
  assign bus.in_ready = (count_q != cnt_t'(DEPTH));
  assign enq          = bus.in_valid && bus.in_ready && !bus.flush;

  // Dequeue count is the run of consecutive ready slots starting at slot 0,
  // clamped to occupancy so a protocol violation cannot corrupt the pointers.
  always_comb begin
    deq_req = '0;
    deq_run = 1'b1;
    for (int i = 0; i < DEQ_W; i++) begin
      deq_run = deq_run & bus.deq_ready[i];
      deq_req = deq_req + cnt_t'(deq_run);
    end
    if (bus.flush)              deq_n = '0;
    else if (deq_req > count_q) deq_n = count_q;
    else                        deq_n = deq_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + ptr_t'(1);
      head_q  <= head_q + ptr_t'(deq_n);
      count_q <= count_q + cnt_t'(enq) - deq_n;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define
  // which entries are live, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (enq) mem[tail_q] <= enq_entry;
  end

  for (genvar i = 0; i < DEQ_W; i++) begin : g_slot
    assign bus.out_valid[i] = (count_q > cnt_t'(i));
    assign bus.out_entry[i] = mem[head_q + ptr_t'(i)];
  end

  assign bus.count = count_q;

  deq_underflow_a: assert property (
    @(posedge clk) disable iff (reset)
    !bus.flush |-> (deq_req <= count_q)
  );

  count_bound_a: assert property (
    @(posedge clk) disable iff (reset)
    count_q <= cnt_t'(DEPTH)
  );

endmodule

// File: tb/tb_predecode_queue.sv
// Scoreboard bench for predecode_queue: the driver pushes hand-computed
// expected entries on accepted enqueues; a negedge monitor pops and compares.
module tb_predecode_queue;
  import predecode_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int DEQ_W = 2;
  localparam int NVEC  = 14;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  predecode_queue_if #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) bus ();

  predecode_queue #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  predec_t     sb[$];

  logic [31:0] vec_pc   [NVEC];
  logic [31:0] vec_inst [NVEC];
  predec_t     vec_exp  [NVEC];

  logic [DEQ_W-1:0] mon_exp_v;
  logic             mon_run;
  int               mon_n;
  int               rnd_sz;
  logic [1:0]       rnd_d;
  logic             rnd_fl;
  logic             rnd_v;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic predec_t base(input logic [31:0] pc, input logic [5:0] op);
    predec_t e;
    e        = '0;
    e.pc     = pc;
    e.opcode = opcode_t'(op);
    return e;
  endfunction

  task automatic init_vectors();
    predec_t e;
    // ADDIU $8,$0,-1
    vec_pc[0] = 32'hBFC0_0000; vec_inst[0] = 32'h2408_FFFF;
    e = base(vec_pc[0], 6'h09); e.rb = 5'd8; e.val_c = 32'hFFFF_FFFF; vec_exp[0] = e;
    // BEQ $0,$0,-1 -> branches to itself
    vec_pc[1] = 32'hBFC0_0010; vec_inst[1] = 32'h1000_FFFF;
    e = base(vec_pc[1], 6'h04); e.is_branch = 1'b1; e.target = 32'hBFC0_0010; vec_exp[1] = e;
    // J 0x100
    vec_pc[2] = 32'hBFC0_0020; vec_inst[2] = 32'h0800_0100;
    e = base(vec_pc[2], 6'h02); e.is_jump = 1'b1; e.target = 32'hB000_0400; vec_exp[2] = e;
    // opcode 0x3F: reserved
    vec_pc[3] = 32'h0040_0000; vec_inst[3] = 32'hFC00_0000;
    e = base(vec_pc[3], 6'h3F); e.rsv = 1'b1; vec_exp[3] = e;
    // LUI $26,0x1234
    vec_pc[4] = 32'h0040_0004; vec_inst[4] = 32'h3C1A_1234;
    e = base(vec_pc[4], 6'h0F); e.rb = 5'd26; e.val_c = 32'h1234_0000; vec_exp[4] = e;
    // ADDU $6,$5,$6
    vec_pc[5] = 32'h0040_0008; vec_inst[5] = 32'h00A6_3021;
    e = base(vec_pc[5], 6'h00); e.ra = 5'd5; e.rb = 5'd6; e.rc = 5'd6;
    e.funct = funct_t'(6'h21); vec_exp[5] = e;
    // JAL 0x0100010
    vec_pc[6] = 32'h0040_000C; vec_inst[6] = 32'h0C10_0010;
    e = base(vec_pc[6], 6'h03); e.is_jump = 1'b1; e.link = 1'b1; e.rc = 5'd31;
    e.target = 32'h0040_0040; vec_exp[6] = e;
    // BGEZAL $0,+3
    vec_pc[7] = 32'h0040_0010; vec_inst[7] = 32'h0411_0003;
    e = base(vec_pc[7], 6'h01); e.btype = btype_t'(5'h11); e.is_branch = 1'b1;
    e.link = 1'b1; e.rc = 5'd31; e.target = 32'h0040_0020; vec_exp[7] = e;
    // JR $31
    vec_pc[8] = 32'h0040_0014; vec_inst[8] = 32'h03E0_0008;
    e = base(vec_pc[8], 6'h00); e.ra = 5'd31; e.funct = funct_t'(6'h08);
    e.is_jump = 1'b1; e.is_indirect = 1'b1; vec_exp[8] = e;
    // ANDI $4,$4,0xFF00 (zero-extended)
    vec_pc[9] = 32'h0040_0018; vec_inst[9] = 32'h3084_FF00;
    e = base(vec_pc[9], 6'h0C); e.ra = 5'd4; e.rb = 5'd4; e.val_c = 32'h0000_FF00; vec_exp[9] = e;
    // LW $4,16($29)
    vec_pc[10] = 32'h0040_001C; vec_inst[10] = 32'h8FA4_0010;
    e = base(vec_pc[10], 6'h23); e.ra = 5'd29; e.rb = 5'd4; e.val_c = 32'h0000_0010; vec_exp[10] = e;
    // BGTZ $2,-2
    vec_pc[11] = 32'h0040_0020; vec_inst[11] = 32'h1C40_FFFE;
    e = base(vec_pc[11], 6'h07); e.ra = 5'd2; e.is_branch = 1'b1; e.target = 32'h0040_001C; vec_exp[11] = e;
    // ADDI: not in the supported subset -> reserved
    vec_pc[12] = 32'h0040_0024; vec_inst[12] = 32'h2001_0005;
    e = base(vec_pc[12], 6'h08); e.rsv = 1'b1; vec_exp[12] = e;
    // BEQ +1 near top of address space: target wraps to 0
    vec_pc[13] = 32'hFFFF_FFF8; vec_inst[13] = 32'h1000_0001;
    e = base(vec_pc[13], 6'h04); e.is_branch = 1'b1; e.target = 32'h0000_0000; vec_exp[13] = e;
  endtask

  // One cycle of stimulus, starting just after a rising edge.
  task automatic step(input logic v, input int idx, input logic [1:0] deq, input logic fl);
    logic acc;
    bus.in_valid  = v;
    bus.in_pc     = vec_pc[idx];
    bus.in_inst   = vec_inst[idx];
    bus.deq_ready = deq;
    bus.flush     = fl;
    @(negedge clk);
    acc = v && bus.in_ready && !fl && !reset;
    @(posedge clk);
    if (acc) sb.push_back(vec_exp[idx]);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      for (int i = 0; i < DEQ_W; i++) mon_exp_v[i] = (sb.size() > i);
      check("count", 160'(bus.count), 160'(sb.size()));
      check("out_valid", 160'(bus.out_valid), 160'(mon_exp_v));
      if (bus.flush) begin
        sb.delete();
      end else begin
        mon_run = 1'b1;
        mon_n   = 0;
        for (int i = 0; i < DEQ_W; i++) begin
          mon_run = mon_run & bus.deq_ready[i];
          if (mon_run && sb.size() > i) begin
            check($sformatf("entry_slot%0d", i), 160'(bus.out_entry[i]), 160'(sb[i]));
            mon_n++;
          end
        end
        repeat (mon_n) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    init_vectors();
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.deq_ready = '0;
    bus.flush     = 1'b0;

    // Asynchronous reset: outputs settle before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_count", 160'(bus.count), 160'(0));
    check("rst_in_ready", 160'(bus.in_ready), 160'(1));
    check("rst_out_valid", 160'(bus.out_valid), 160'(0));
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single enqueue, visible next cycle, then dequeue.
    step(1'b1, 0, 2'b00, 1'b0);
    step(1'b0, 0, 2'b00, 1'b0);
    step(1'b0, 0, 2'b01, 1'b0);

    // Branch and jump, dequeued together.
    step(1'b1, 1, 2'b00, 1'b0);
    step(1'b1, 2, 2'b00, 1'b0);
    step(1'b0, 0, 2'b11, 1'b0);

    // Fill to DEPTH with no dequeue.
    for (int k = 0; k < DEPTH; k++) step(1'b1, 3 + k, 2'b00, 1'b0);
    check("full_count", 160'(bus.count), 160'(DEPTH));
    check("full_in_ready", 160'(bus.in_ready), 160'(0));
    step(1'b1, 11, 2'b00, 1'b0);
    check("full_hold_count", 160'(bus.count), 160'(DEPTH));

    // Full with double dequeue: word waits until in_ready returns.
    step(1'b1, 11, 2'b11, 1'b0);
    check("after_deq_count", 160'(bus.count), 160'(DEPTH - 2));
    check("after_deq_in_ready", 160'(bus.in_ready), 160'(1));
    step(1'b1, 11, 2'b00, 1'b0);
    check("late_enq_count", 160'(bus.count), 160'(DEPTH - 1));

    // Down to 5 entries, then flush with enqueue and dequeue also requested.
    step(1'b0, 0, 2'b11, 1'b0);
    check("pre_flush_count", 160'(bus.count), 160'(5));
    step(1'b1, 12, 2'b11, 1'b1);
    check("flush_count", 160'(bus.count), 160'(0));
    check("flush_out_valid", 160'(bus.out_valid), 160'(0));
    check("flush_in_ready", 160'(bus.in_ready), 160'(1));
    step(1'b1, 13, 2'b00, 1'b0);
    step(1'b0, 0, 2'b00, 1'b0);
    step(1'b0, 0, 2'b01, 1'b0);

    // Reset asserted mid-operation with entries queued.
    step(1'b1, 0, 2'b00, 1'b0);
    step(1'b1, 1, 2'b00, 1'b0);
    step(1'b1, 2, 2'b00, 1'b0);
    bus.in_valid  = 1'b0;
    bus.deq_ready = 2'b00;
    #2 reset = 1'b1;
    #1;
    check("midrst_count", 160'(bus.count), 160'(0));
    check("midrst_in_ready", 160'(bus.in_ready), 160'(1));
    check("midrst_out_valid", 160'(bus.out_valid), 160'(0));
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic, always protocol-legal, crossing the pointer wrap many times.
    for (int k = 0; k < 600; k++) begin
      rnd_sz = sb.size();
      if (rnd_sz >= 2)      rnd_d = 2'($urandom_range(0, 3));
      else if (rnd_sz == 1) rnd_d = 2'($urandom_range(0, 2));
      else                  rnd_d = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
      rnd_fl = ($urandom_range(0, 99) < 2);
      rnd_v  = ($urandom_range(0, 99) < 65);
      step(rnd_v, k % NVEC, rnd_d, rnd_fl);
    end

    step(1'b0, 0, 2'b00, 1'b0);
    step(1'b0, 0, 2'b00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/predecode_queue.md
Name: predecode_queue

Overview:
- Parametrised successor to the single-cycle fetch predecoder.
- Accepts raw instruction words with their PCs from the fetch stage and predecodes each word: register fields, immediates, branch/jump targets and class flags.
- Stores predecoded entries in a DEPTH-entry circular queue and presents up to DEQ_W oldest entries per cycle to decode.
- Sits between the ibus response path and the decode stage, and decouples fetch from decode stalls.

Parameters:
- DEPTH, 8, number of queue entries; power of two, must be at least 2.
- DEQ_W, 2, maximum entries dequeued per cycle; legal values are 1 or 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents a word this cycle.
- in_ready  output  1  queue can accept a word.
- in_pc  input  32  PC of the presented word.
- in_inst  input  32  raw instruction word.
- flush  input  1  discard all queued entries (branch redirect or exception).
- out_valid  output  DEQ_W  out_valid[i] means slot i holds the i-th oldest entry.
- out_entry  output  DEQ_W x predec_t  predecoded entries, oldest in slot 0.
- deq_ready  input  DEQ_W  consumer takes slot i this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous, active-high): head=0, tail=0, count=0; out_valid=0 and in_ready=1 immediately on reset assertion. Entry storage is not reset.
- Enqueue fires when in_valid && in_ready. The word is predecoded combinationally and written at tail, then tail advances modulo DEPTH.
- Enqueue-to-visibility latency is one cycle. There is no bypass: an entry written in cycle t can appear at out_entry[0] no earlier than cycle t+1.
- in_ready = (count != DEPTH). It is registered-state-based only and does not depend on same-cycle dequeue, so there is no pass-through when full.
- out_valid[i] = (count > i) && !flush_q, where flush_q is not used (see flush). Equivalently, out_valid[i] = count > i. out_entry[i] = mem[(head+i) mod DEPTH].
- Dequeue number n = deq_ready[0] + (deq_ready[0] & deq_ready[1]). deq_ready[1] without deq_ready[0] is ignored.
- Dequeueing a slot whose out_valid is low is a protocol violation. An assertion must flag it; the RTL clamps n to count.
- On dequeue, head advances by n modulo DEPTH.
- count_next = count + enq - n, with all arithmetic modulo-free within [0, DEPTH].
- Simultaneous enqueue and dequeue is legal whenever in_ready is high.
- flush: in the flush cycle, enqueue and dequeue are both ignored. Next cycle head=tail=0, count=0, out_valid=0, in_ready=1.
- flush takes priority over all other events.
- Reset asserted mid-operation discards all entries with the same effect as flush, but asynchronously.
- Predecode rules (32-bit, MIPS I subset):
  - All entries record pc, opcode, and rsv=0.
  - RTYPE: rA=[25:21], rB=[20:16], rC=[15:11], shamt=[10:6], funct=[5:0].
  - LUI: rB, valC={imm,16'b0}.
  - ADDIU, SLTI, SLTIU, loads and stores: rA, rB, valC=sign-extended imm.
  - ANDI, ORI, XORI: rA, rB, valC=zero-extended imm.
  - BEQ, BNE: rA, rB. BGTZ, BLEZ: rA. BTYPE: rA, btype=[20:16].
  - All branches: is_branch=1, target=pc+4+sext(imm<<2) (32-bit wrap).
  - J, JAL: is_jump=1, target={(pc+4)[31:28],[25:0],2'b00}.
  - JAL, plus BTYPE with link (BLTZAL, BGEZAL): link=1, rC=31.
  - RTYPE JR/JALR: is_jump=1, is_indirect=1; JALR also sets link=1.
  - Any unlisted opcode: rsv=1 and all other fields zero.
  - Unused fields are zero.

Decomposition:
- Shared package (mycpu defs) holds:
  - predec_t struct: pc, opcode, rA, rB, rC, shamt, funct, btype, valC, target, is_branch, is_jump, is_indirect, link, rsv.
  - Existing opcode_t, funct_t, btype_t and regid_t.
  - Opcode-class localparams.
- Sub-module predecode_unit: purely combinational, pc+inst -> predec_t. It is instantiated once on the enqueue side and keeps the queue logic free of decode detail.

Test Plan:
- Reset, then enqueue 0x2408FFFF at pc 0xBFC00000 -> next cycle out_valid=01, rA=0, rB=8, valC=0xFFFFFFFF, rsv=0.
- Enqueue 0x1000FFFF at pc 0xBFC00010 -> is_branch=1, target=0xBFC00010. Enqueue 0x08000100 at pc 0xBFC00020 -> is_jump=1, target=0xB0000400.
- DEPTH=8, deq_ready=0, 8 enqueues -> count=8, in_ready=0. A 9th in_valid is not accepted, and the queue contents are unchanged.
- Full queue with deq_ready=11 and in_valid high for one cycle -> count 8->6, and the first two PCs emerge in order. Next cycle in_ready=1; the enqueue occurs only then.
- 5 entries queued with flush, in_valid and deq_ready all high -> next cycle count=0, out_valid=00, and the flush-cycle word is dropped.
- Long random enqueue/dequeue run crossing the pointer wrap several times -> output PC order equals input order, and opcode 0x3F yields rsv=1.
